teller_dispatcher: RTL and testbench

- Sequences the bank queue service: when customers are waiting (Pcount from SBqM) and an on-duty teller is free, calls the next customer to that teller.
- Shares the queue head among up to 3 tellers round-robin and pulses dequeue so the queue count can be decremented.
- Supplies SBqM's Tcount input from the live on-duty mask.
- Sits between the SBqM queue counter and the teller-desk buttons/call display.

---
 rtl/teller_dispatcher.sv | 123 ++++++++++++
 tb/tb_teller_dispatcher.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/teller_dispatcher.sv
// Calls the next queued customer to a free on-duty teller, round-robin over
// three desks, and pulses dequeue once per call so the queue counter can step down.
module teller_dispatcher #(
  parameter int CNT_W       = 3,
  parameter int CALL_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] Pcount,
  input  logic [2:0]       on_duty,
  input  logic [2:0]       done,
  output logic             dequeue,
  output logic             call_valid,
  output logic [1:0]       call_teller,
  output logic [2:0]       busy,
  output logic [1:0]       Tcount,
  output logic             all_busy
);

  typedef enum logic {IDLE, CALL} state_t;

  localparam logic [3:0] TIMER_INIT = 4'(CALL_CYCLES - 1);

  state_t     state_q, state_d;
  logic [2:0] busy_q, busy_d;
  logic       dequeue_q, dequeue_d;
  logic       call_valid_q, call_valid_d;
  logic [1:0] call_teller_q, call_teller_d;
  logic [1:0] tcount_q, tcount_d;
  logic       all_busy_q, all_busy_d;
  logic [1:0] rr_ptr_q, rr_ptr_d;
  logic [3:0] timer_q, timer_d;

  logic [2:0] eligible;
  logic [1:0] cand1, cand2;
  logic       grant_found;
  logic [1:0] grant_idx;

  function automatic logic [1:0] next3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // Search order after the last grant: rr+1, rr+2, then rr itself.
  always_comb begin
    eligible    = on_duty & ~busy_q;
    cand1       = next3(rr_ptr_q);
    cand2       = next3(cand1);
    grant_found = 1'b1;
    grant_idx   = cand1;
    if (eligible[cand1])         grant_idx = cand1;
    else if (eligible[cand2])    grant_idx = cand2;
    else if (eligible[rr_ptr_q]) grant_idx = rr_ptr_q;
    else                         grant_found = 1'b0;
  end

  always_comb begin
    state_d       = state_q;
    busy_d        = busy_q & ~done;
    dequeue_d     = 1'b0;
    call_valid_d  = call_valid_q;
    call_teller_d = call_teller_q;
    rr_ptr_d      = rr_ptr_q;
    timer_d       = timer_q;
    tcount_d      = {1'b0, on_duty[0]} + {1'b0, on_duty[1]} + {1'b0, on_duty[2]};
    all_busy_d    = (eligible == 3'b000);
    case (state_q)
      IDLE: begin
        if (Pcount != '0 && grant_found) begin
          // The grant wins over a done level on the same teller.
          busy_d[grant_idx] = 1'b1;
          call_teller_d     = grant_idx + 2'd1;
          call_valid_d      = 1'b1;
          dequeue_d         = 1'b1;
          rr_ptr_d          = grant_idx;
          timer_d           = TIMER_INIT;
          state_d           = CALL;
        end
      end
      CALL: begin
        if (timer_q == 4'd0) begin
          call_valid_d  = 1'b0;
          call_teller_d = 2'd0;
          state_d       = IDLE;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= IDLE;
      busy_q        <= 3'b000;
      dequeue_q     <= 1'b0;
      call_valid_q  <= 1'b0;
      call_teller_q <= 2'd0;
      tcount_q      <= 2'd0;
      all_busy_q    <= 1'b1;
      rr_ptr_q      <= 2'd2;
      timer_q       <= 4'd0;
    end else begin
      state_q       <= state_d;
      busy_q        <= busy_d;
      dequeue_q     <= dequeue_d;
      call_valid_q  <= call_valid_d;
      call_teller_q <= call_teller_d;
      tcount_q      <= tcount_d;
      all_busy_q    <= all_busy_d;
      rr_ptr_q      <= rr_ptr_d;
      timer_q       <= timer_d;
    end
  end

  assign dequeue     = dequeue_q;
  assign call_valid  = call_valid_q;
  assign call_teller = call_teller_q;
  assign busy        = busy_q;
  assign Tcount      = tcount_q;
  assign all_busy    = all_busy_q;

endmodule

// File: tb/tb_teller_dispatcher.sv
// Cycle-by-cycle vector table for teller_dispatcher; each row's expected outputs
// go into a scoreboard queue when its inputs are driven and are checked after the edge.
module tb_teller_dispatcher;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [2:0] Pcount = 3'd0;
  logic [2:0] on_duty = 3'b000;
  logic [2:0] done = 3'b000;
  logic       dequeue, call_valid, all_busy;
  logic [1:0] call_teller, Tcount;
  logic [2:0] busy;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  teller_dispatcher #(.CNT_W(3), .CALL_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .Pcount(Pcount), .on_duty(on_duty), .done(done),
    .dequeue(dequeue), .call_valid(call_valid), .call_teller(call_teller),
    .busy(busy), .Tcount(Tcount), .all_busy(all_busy)
  );

  // exp = {dequeue, call_valid, call_teller[1:0], busy[2:0], Tcount[1:0], all_busy}
  typedef struct {
    logic       r;
    logic [2:0] on;
    logic [2:0] dn;
    logic [2:0] pc;
    logic [9:0] exp;
  } vec_t;

  vec_t table_q[$];
  vec_t sb_q[$];

  function automatic void v(input logic r, input logic [2:0] on, input logic [2:0] dn,
                            input logic [2:0] pc, input logic deq, input logic cv,
                            input logic [1:0] ct, input logic [2:0] b, input logic [1:0] tc,
                            input logic ab);
    vec_t e;
    e.r = r; e.on = on; e.dn = dn; e.pc = pc;
    e.exp = {deq, cv, ct, b, tc, ab};
    table_q.push_back(e);
  endfunction

  task automatic apply(input vec_t e, input int idx);
    vec_t s;
    logic [9:0] got;
    @(negedge clk);
    rst = e.r; on_duty = e.on; done = e.dn; Pcount = e.pc;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    s = sb_q.pop_front();
    got = {dequeue, call_valid, call_teller, busy, Tcount, all_busy};
    checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL step%0d: got deq=%b cv=%b ct=%0d busy=%b tc=%0d ab=%b, expected deq=%b cv=%b ct=%0d busy=%b tc=%0d ab=%b",
               idx, got[9], got[8], got[7:6], got[5:3], got[2:1], got[0],
               s.exp[9], s.exp[8], s.exp[7:6], s.exp[5:3], s.exp[2:1], s.exp[0]);
    end else begin
      $display("step%0d ok: deq=%b cv=%b ct=%0d busy=%b tc=%0d ab=%b",
               idx, got[9], got[8], got[7:6], got[5:3], got[2:1], got[0]);
    end
  endtask

  initial begin
    int n;
    vec_t h;

    // Single teller on duty: one call to teller 0, held 4 cycles.
    v(0,3'b001,3'b000,3'd2, 0,0,2'd0,3'b000,2'd0,1);
    v(1,3'b001,3'b000,3'd2, 1,1,2'd1,3'b001,2'd1,0);
    v(1,3'b001,3'b000,3'd2, 0,1,2'd1,3'b001,2'd1,1);
    v(1,3'b001,3'b000,3'd2, 0,1,2'd1,3'b001,2'd1,1);
    v(1,3'b001,3'b000,3'd2, 0,1,2'd1,3'b001,2'd1,1);
    v(1,3'b001,3'b000,3'd2, 0,0,2'd0,3'b001,2'd1,1);
    v(1,3'b001,3'b000,3'd2, 0,0,2'd0,3'b001,2'd1,1);
    // Three tellers from reset: calls 1, 2, 3 then stall with all busy.
    v(0,3'b111,3'b000,3'd3, 0,0,2'd0,3'b000,2'd0,1);
    v(1,3'b111,3'b000,3'd3, 1,1,2'd1,3'b001,2'd3,0);
    for (int i = 0; i < 3; i++) v(1,3'b111,3'b000,3'd3, 0,1,2'd1,3'b001,2'd3,0);
    v(1,3'b111,3'b000,3'd3, 0,0,2'd0,3'b001,2'd3,0);
    v(1,3'b111,3'b000,3'd3, 1,1,2'd2,3'b011,2'd3,0);
    for (int i = 0; i < 3; i++) v(1,3'b111,3'b000,3'd3, 0,1,2'd2,3'b011,2'd3,0);
    v(1,3'b111,3'b000,3'd3, 0,0,2'd0,3'b011,2'd3,0);
    v(1,3'b111,3'b000,3'd3, 1,1,2'd3,3'b111,2'd3,0);
    for (int i = 0; i < 3; i++) v(1,3'b111,3'b000,3'd3, 0,1,2'd3,3'b111,2'd3,1);
    v(1,3'b111,3'b000,3'd3, 0,0,2'd0,3'b111,2'd3,1);
    v(1,3'b111,3'b000,3'd3, 0,0,2'd0,3'b111,2'd3,1);
    v(1,3'b111,3'b000,3'd3, 0,0,2'd0,3'b111,2'd3,1);
    // Teller 1 finishes; it is re-called on the following IDLE cycle.
    v(1,3'b111,3'b010,3'd1, 0,0,2'd0,3'b101,2'd3,1);
    v(1,3'b111,3'b000,3'd1, 1,1,2'd2,3'b111,2'd3,0);
    for (int i = 0; i < 3; i++) v(1,3'b111,3'b000,3'd1, 0,1,2'd2,3'b111,2'd3,1);
    v(1,3'b111,3'b000,3'd1, 0,0,2'd0,3'b111,2'd3,1);
    // Everyone free but queue empty: nothing may be called.
    v(1,3'b111,3'b111,3'd0, 0,0,2'd0,3'b000,2'd3,1);
    for (int i = 0; i < 20; i++) v(1,3'b111,3'b000,3'd0, 0,0,2'd0,3'b000,2'd3,0);
    // Reset in the second CALL cycle aborts the call and restores rr_ptr.
    v(1,3'b011,3'b000,3'd1, 1,1,2'd1,3'b001,2'd2,0);
    v(1,3'b011,3'b000,3'd1, 0,1,2'd1,3'b001,2'd2,0);
    v(0,3'b011,3'b000,3'd1, 0,0,2'd0,3'b000,2'd0,1);
    v(1,3'b011,3'b000,3'd1, 1,1,2'd1,3'b001,2'd2,0);
    for (int i = 0; i < 3; i++) v(1,3'b011,3'b000,3'd0, 0,1,2'd1,3'b001,2'd2,0);
    v(1,3'b011,3'b000,3'd0, 0,0,2'd0,3'b001,2'd2,0);
    // Stray done on an idle teller; busy teller leaving duty stays busy until done.
    v(1,3'b011,3'b100,3'd0, 0,0,2'd0,3'b001,2'd2,0);
    v(1,3'b010,3'b000,3'd0, 0,0,2'd0,3'b001,2'd1,0);
    v(1,3'b000,3'b000,3'd1, 0,0,2'd0,3'b001,2'd0,1);
    v(1,3'b000,3'b001,3'd1, 0,0,2'd0,3'b000,2'd0,1);
    v(1,3'b010,3'b000,3'd1, 1,1,2'd2,3'b010,2'd1,0);

    foreach (table_q[i]) apply(table_q[i], i);

    // done held high across a grant: grant wins, then the level clears busy.
    h.r = 0; h.on = 3'b001; h.dn = 3'b000; h.pc = 3'd1; h.exp = {1'b0,1'b0,2'd0,3'b000,2'd0,1'b1};
    apply(h, 100);
    h.r = 1; h.dn = 3'b001; h.exp = {1'b1,1'b1,2'd1,3'b001,2'd1,1'b0};
    apply(h, 101);
    h.exp = {1'b0,1'b1,2'd1,3'b000,2'd1,1'b1};
    apply(h, 102);
    h.dn = 3'b000; h.pc = 3'd0; h.exp = {1'b0,1'b1,2'd1,3'b000,2'd1,1'b0};
    apply(h, 103);

    n = 0;
    while (call_valid && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL call_release: call_valid fell after %0d cycles, expected 2", n);
    end else begin
      $display("call_release ok: call_valid fell after %0d cycles", n);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
